// File: rtl/tile_scanner.sv
// ============================================================================
// Module  : tile_scanner
// Purpose : tile-map lookup for a scanning video beam, plus a command port
//           for writing, rotating and clearing tiles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tile_scanner #(
  parameter int COLS = 32,
  parameter int ROWS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       display_on,
  input  logic [8:0] hpos,
  input  logic [8:0] vpos,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_col,
  input  logic [4:0] cmd_row,
  input  logic [3:0] cmd_data,
  output logic [1:0] tile_type,
  output logic [1:0] rotation,
  output logic [2:0] yin,
  output logic [2:0] xin,
  output logic       pix_valid
);

  localparam int          C_DEPTH = COLS * ROWS;
  localparam int          C_AW    = $clog2(C_DEPTH);
  localparam logic [31:0] C_COLS  = 32'(COLS);
  localparam logic [31:0] C_ROWS  = 32'(ROWS);
  localparam logic [31:0] C_HMAX  = 32'(COLS * 8);
  localparam logic [31:0] C_VMAX  = 32'(ROWS * 8);
  localparam logic [C_AW-1:0] C_LAST = C_AW'(C_DEPTH - 1);

  localparam logic [1:0] C_OP_WRITE = 2'b00;
  localparam logic [1:0] C_OP_ROT   = 2'b01;
  localparam logic [1:0] C_OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RMW_RD = 2'd1,
    S_RMW_WR = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  state_t            state_q;
  logic              cmd_ready_q;
  logic [C_AW-1:0]   clr_cnt_q;
  logic [C_AW-1:0]   rmw_addr_q;
  logic              rmw_ok_q;

  logic [3:0]        mem_q [C_DEPTH];
  logic [3:0]        cmd_rd_q;
  logic [3:0]        vid_rd_q;

  logic              vid_valid1_q, vid_valid2_q;
  logic [C_AW-1:0]   vid_addr_q;
  logic [2:0]        vid_y1_q, vid_x1_q, vid_y2_q, vid_x2_q;

  logic              pix_valid_q;
  logic [1:0]        tile_type_q, rotation_q;
  logic [2:0]        yin_q, xin_q;

  logic              cmd_in_range, vid_in_range, accept;
  logic [C_AW-1:0]   cmd_addr, vid_addr;
  logic              mem_we;
  logic [C_AW-1:0]   mem_waddr;
  logic [3:0]        mem_wdata;

  assign cmd_in_range = (32'(cmd_row) < C_ROWS) && (32'(cmd_col) < C_COLS);
  assign cmd_addr     = cmd_in_range ? C_AW'(32'(cmd_row) * C_COLS + 32'(cmd_col)) : '0;
  assign vid_in_range = display_on && (32'(hpos) < C_HMAX) && (32'(vpos) < C_VMAX);
  assign vid_addr     = vid_in_range ? C_AW'(32'(vpos[7:3]) * C_COLS + 32'(hpos[7:3])) : '0;
  assign accept       = cmd_valid && cmd_ready_q;

  // Single write port shared by direct writes, the rotate write-back and the sweep.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cmd_addr;
    mem_wdata = cmd_data;
    if (reset) begin
      case (state_q)
        S_IDLE:   mem_we = accept && (cmd_op == C_OP_WRITE) && cmd_in_range;
        S_RMW_RD: begin
          mem_we    = rmw_ok_q;
          mem_waddr = rmw_addr_q;
          mem_wdata = {cmd_rd_q[3:2], cmd_rd_q[1:0] + 2'd1};
        end
        S_CLEAR:  begin
          mem_we    = 1'b1;
          mem_waddr = clr_cnt_q;
          mem_wdata = 4'd0;
        end
        default:  ;
      endcase
    end
  end

  // Reads return the pre-write contents when they collide with a write.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    cmd_rd_q <= mem_q[cmd_addr];
    vid_rd_q <= mem_q[vid_addr_q];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_CLEAR;
      cmd_ready_q <= 1'b0;
      clr_cnt_q   <= '0;
      rmw_addr_q  <= '0;
      rmw_ok_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (cmd_op == C_OP_ROT) begin
              state_q     <= S_RMW_RD;
              cmd_ready_q <= 1'b0;
              rmw_addr_q  <= cmd_addr;
              rmw_ok_q    <= cmd_in_range;
            end else if (cmd_op == C_OP_CLEAR) begin
              state_q     <= S_CLEAR;
              cmd_ready_q <= 1'b0;
              clr_cnt_q   <= '0;
            end
          end
        end
        S_RMW_RD: state_q <= S_RMW_WR;
        S_RMW_WR: begin
          state_q     <= S_IDLE;
          cmd_ready_q <= 1'b1;
        end
        S_CLEAR: begin
          if (clr_cnt_q == C_LAST) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  // Three register levels: address, memory read, output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vid_valid1_q <= 1'b0;
      vid_addr_q   <= '0;
      vid_y1_q     <= 3'd0;
      vid_x1_q     <= 3'd0;
      vid_valid2_q <= 1'b0;
      vid_y2_q     <= 3'd0;
      vid_x2_q     <= 3'd0;
      pix_valid_q  <= 1'b0;
      tile_type_q  <= 2'd0;
      rotation_q   <= 2'd0;
      yin_q        <= 3'd0;
      xin_q        <= 3'd0;
    end else begin
      vid_valid1_q <= vid_in_range;
      vid_addr_q   <= vid_addr;
      vid_y1_q     <= vpos[2:0];
      vid_x1_q     <= hpos[2:0];
      vid_valid2_q <= vid_valid1_q;
      vid_y2_q     <= vid_y1_q;
      vid_x2_q     <= vid_x1_q;
      pix_valid_q  <= vid_valid2_q && (state_q != S_CLEAR);
      tile_type_q  <= (vid_valid2_q && (state_q != S_CLEAR)) ? vid_rd_q[3:2] : 2'd0;
      rotation_q   <= (vid_valid2_q && (state_q != S_CLEAR)) ? vid_rd_q[1:0] : 2'd0;
      yin_q        <= vid_y2_q;
      xin_q        <= vid_x2_q;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign pix_valid = pix_valid_q;
  assign tile_type = tile_type_q;
  assign rotation  = rotation_q;
  assign yin       = yin_q;
  assign xin       = xin_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_scanner.sv
// ============================================================================
// Module  : tb_tile_scanner
// Purpose : directed self-checking bench for tile_scanner.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tile_scanner;

  logic       clk = 1'b0;
  logic       reset;
  logic       display_on;
  logic [8:0] hpos, vpos;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_col, cmd_row;
  logic [3:0] cmd_data;
  logic [1:0] tile_type, rotation;
  logic [2:0] yin, xin;
  logic       pix_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_busy;

  always #5 clk = ~clk;

  tile_scanner #(.COLS(32), .ROWS(30)) dut (
    .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_col(cmd_col), .cmd_row(cmd_row), .cmd_data(cmd_data),
    .tile_type(tile_type), .rotation(rotation), .yin(yin), .xin(xin),
    .pix_valid(pix_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input string tag, input logic [8:0] h, input logic [8:0] v,
                       input logic de, input logic [1:0] et, input logic [1:0] er,
                       input logic ev);
    hpos = h; vpos = v; display_on = de;
    repeat (3) tick();
    check({tag, ".valid"}, pix_valid, ev);
    check({tag, ".type"},  tile_type, et);
    check({tag, ".rot"},   rotation,  er);
    check({tag, ".yin"},   yin,       v[2:0]);
    check({tag, ".xin"},   xin,       h[2:0]);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] c, input logic [4:0] r,
                      input logic [3:0] d);
    cmd_valid = 1'b1; cmd_op = op; cmd_col = c; cmd_row = r; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b0; display_on = 1'b1; hpos = 9'd29; vpos = 9'd17;
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_col = 5'd0; cmd_row = 5'd0; cmd_data = 4'd0;
    repeat (4) tick();
    check("rst.ready", cmd_ready, 0);
    check("rst.valid", pix_valid, 0);
    check("rst.type",  tile_type, 0);
    check("rst.yin",   yin, 0);
    check("rst.xin",   xin, 0);

    // Power-up sweep
    reset = 1'b1;
    count_busy(n_busy);
    check("rst.sweep_cycles", n_busy, 960);
    pixel("init_29_17", 9'd29, 9'd17, 1'b1, 2'd0, 2'd0, 1'b1);
    pixel("init_255_239", 9'd255, 9'd239, 1'b1, 2'd0, 2'd0, 1'b1);

    // Write then read with latency check
    send(2'b00, 5'd3, 5'd2, 4'b1001);
    check("wr.ready_stays", cmd_ready, 1);
    pixel("lat_prev", 9'd0, 9'd0, 1'b1, 2'd0, 2'd0, 1'b1);
    hpos = 9'd29; vpos = 9'd17;
    tick(); tick();
    check("lat.xin_old",  xin, 0);
    check("lat.type_old", tile_type, 0);
    tick();
    check("wr.valid", pix_valid, 1);
    check("wr.type",  tile_type, 2);
    check("wr.rot",   rotation, 1);
    check("wr.yin",   yin, 1);
    check("wr.xin",   xin, 5);

    // Rotate with wrap; inputs change while busy
    send(2'b00, 5'd3, 5'd2, 4'b1011);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_col = 5'd3; cmd_row = 5'd2; cmd_data = 4'd0;
    tick();
    cmd_op = 2'b00; cmd_col = 5'd7; cmd_row = 5'd0; cmd_data = 4'hF;
    check("rot.busy1", cmd_ready, 0);
    tick();
    check("rot.busy2", cmd_ready, 0);
    tick();
    check("rot.ready", cmd_ready, 1);
    cmd_valid = 1'b0;
    pixel("rot_wrap", 9'd24, 9'd16, 1'b1, 2'd2, 2'd0, 1'b1);
    pixel("rot_ignored", 9'd56, 9'd0, 1'b1, 2'd0, 2'd0, 1'b1);
    send(2'b01, 5'd3, 5'd2, 4'd0);
    tick(); tick();
    check("rot2.ready", cmd_ready, 1);
    pixel("rot_second", 9'd30, 9'd22, 1'b1, 2'd2, 2'd1, 1'b1);

    // Out of range and dropped commands
    send(2'b00, 5'd0, 5'd0, 4'hF);
    pixel("oor_h256", 9'd258, 9'd1, 1'b1, 2'd0, 2'd0, 1'b0);
    pixel("oor_v240", 9'd0, 9'd240, 1'b1, 2'd0, 2'd0, 1'b0);
    pixel("oor_de0", 9'd0, 9'd0, 1'b0, 2'd0, 2'd0, 1'b0);
    pixel("cell00", 9'd0, 9'd0, 1'b1, 2'd3, 2'd3, 1'b1);
    send(2'b00, 5'd0, 5'd31, 4'h5);
    send(2'b11, 5'd0, 5'd0, 4'h0);
    check("noop.ready", cmd_ready, 1);
    pixel("row31_noop", 9'd3, 9'd4, 1'b1, 2'd3, 2'd3, 1'b1);
    pixel("row29_untouched", 9'd0, 9'd232, 1'b1, 2'd0, 2'd0, 1'b1);

    // Same-edge video read and command write
    hpos = 9'd40; vpos = 9'd32; display_on = 1'b1;
    tick();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_col = 5'd5; cmd_row = 5'd4; cmd_data = 4'b0110;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rbw.old_type", tile_type, 0);
    check("rbw.old_rot",  rotation, 0);
    tick();
    check("rbw.new_type", tile_type, 1);
    check("rbw.new_rot",  rotation, 2);

    // Clear-all command
    send(2'b10, 5'd0, 5'd0, 4'd0);
    hpos = 9'd24; vpos = 9'd16; display_on = 1'b1;
    repeat (3) tick();
    check("clr.pix_valid", pix_valid, 0);
    check("clr.type", tile_type, 0);
    count_busy(n_busy);
    check("clr.cycles", n_busy, 957);
    pixel("clr_cell32", 9'd24, 9'd16, 1'b1, 2'd0, 2'd0, 1'b1);
    pixel("clr_cell00", 9'd0, 9'd0, 1'b1, 2'd0, 2'd0, 1'b1);

    // Reset in the middle of a sweep
    send(2'b00, 5'd3, 5'd2, 4'hF);
    send(2'b10, 5'd0, 5'd0, 4'd0);
    repeat (500) tick();
    reset = 1'b0;
    tick();
    check("midrst.ready", cmd_ready, 0);
    check("midrst.valid", pix_valid, 0);
    reset = 1'b1;
    count_busy(n_busy);
    check("midrst.cycles", n_busy, 960);
    pixel("midrst_cell", 9'd24, 9'd16, 1'b1, 2'd0, 2'd0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
